output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  Round-robin arbiter plus single-entry output register for one router output port (L/R/U/D/PE).
//  Collects the 5-bit one-hot requests that the five per-input routing units raise toward this port.
//  Picks one winner, registers its 64-bit flit and presents it downstream with a valid/ready handshake.
//  Acknowledges the winner with a one-cycle grant pulse. One instance per output port per router.
// PARAMETERS
//  DATA_WIDTH  64      flit width
//  NUM_IN      5       requesters; bit map [0]=PE [1]=L [2]=R [3]=U [4]=D
//  PTR_RESET   0       requester index holding highest priority after reset (0..NUM_IN-1)
// PORTS
//  clk         in   1                    rising-edge clock
//  reset       in   1                    synchronous, active-high
//  req         in   NUM_IN               one-hot-per-requester request vector (bit i = input i wants this port)
//  data_in     in   NUM_IN*DATA_WIDTH    flattened flits; input i at [i*DATA_WIDTH +: DATA_WIDTH]
//  grant       out  NUM_IN               one-cycle ack pulse to winning input
//  out_valid   out  1                    output register holds a flit
//  out_data    out  DATA_WIDTH           registered flit
//  out_ready   in   1                    downstream buffer can accept this cycle
//  grant_cnt   out  NUM_IN*16            per-input grant counters (only with ARB_GRANT_CNT_EN)
// BEHAVIOUR
//  Reset: grant=0, out_valid=0, out_data=0, ptr=PTR_RESET, grant_cnt=0.
//  Two states: EMPTY (out_valid=0), FULL (out_valid=1).
//  - Transfer: out_valid && out_ready at a rising edge retires the flit.
//  - Slot free: out_valid==0, or a transfer occurs in the same cycle (bypass on drain; full throughput).
//  Arbitration runs only when the slot is free.
//  - Eligible set: req & ~grant. A requester whose grant pulse is high this cycle is masked, so it is
//    never double-granted while it drops req.
//  - Winner: first eligible index scanning ptr, ptr+1, ... wrapping modulo NUM_IN.
//  On a win at edge N:
//  - out_data <= winner's flit; out_valid <= 1.
//  - grant <= onehot(winner) for the cycle after edge N, then 0.
//  - ptr <= (winner+1) mod NUM_IN; wrap 4->0.
//  Latency: req high before edge N with the slot free -> out_valid and grant high in cycle N+1.
//  No eligible request with the slot free:
//  - EMPTY: out_valid <= 0.
//  - FULL with a transfer: out_valid <= 0.
//  - ptr unchanged.
//  Slot busy (FULL, no out_ready): no grant, ptr frozen, out_data stable; requesters keep req asserted.
//  Requester contract: holds req and data_in stable until it sees grant, then deasserts req next cycle.
//  grant is always one-hot or zero; never more than one bit set.
//  req bits are independent; several may be set simultaneously. Only grant is one-hot.
//  Reset asserted mid-operation discards any held flit and any pending grant on that edge. The same
//  edge restores ptr to PTR_RESET.
//  out_ready while out_valid==0 is ignored.
// CONFIGURATION
//  ARB_GRANT_CNT_EN defined:
//  - grant_cnt port exists; counter i increments on every grant to input i.
//  - Counters are 16-bit, wrap 0xFFFF->0, and are cleared by reset.
//  ARB_GRANT_CNT_EN undefined: grant_cnt port and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: after reset, grant=0, out_valid=0, out_data=0; out_ready=1 for 3 cycles -> nothing appears.
//  2 Single req: req=00100, data_in[2]=64'hA5, out_ready=1 -> next cycle grant=00100, out_valid=1,
//    out_data=64'hA5; ptr becomes 3.
//  3 Round robin: req=11111 held (requesters drop on grant and re-raise), out_ready=1 ->
//    grant order 0,1,2,3,4,0; one flit per cycle.
//  4 Backpressure:
//    - With out_valid=1 and out_ready=0 for 4 cycles, req=00010 -> no grant and out_data stable.
//    - out_ready=1 -> flit retires and input 1 loads on the same edge; grant=00010 the following cycle.
//  5 Wrap/priority: ptr=4, req=10001 -> input 4 wins, ptr->0; input 0 then wins the next free slot.
//  6 Mid reset: reset during FULL with req pending -> out_valid=0 and grant=0 next cycle; ptr=PTR_RESET.
//    With ARB_GRANT_CNT_EN: 65536 grants to input 0 -> grant_cnt[15:0] wraps to 0.

Source files
------------

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter with a single-entry output register for one router output port.
// Optional per-input 16-bit grant counters are built when ARB_GRANT_CNT_EN is defined.
module output_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 5,
    parameter int PTR_RESET  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            req,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    output logic [NUM_IN-1:0]            grant,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [NUM_IN*16-1:0]         grant_cnt
`endif
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state_reg, state_next;
    logic [PTR_W-1:0]        ptr_reg;
    logic [NUM_IN-1:0]       grant_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [NUM_IN-1:0]       eligible;
    logic [NUM_IN-1:0]       win_onehot;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        ptr_next;
    logic                    found;
    logic                    load;
    logic [DATA_WIDTH-1:0]   in_flit [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_in
            assign in_flit[gi]    = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign win_onehot[gi] = (winner == PTR_W'(gi));
        end
    endgenerate

    // A requester whose grant is visible this cycle is still holding req; mask it.
    assign eligible = req & ~grant_reg;

    // Scan from the highest offset down so the lowest offset from ptr wins last.
    always_comb begin
        logic [PTR_W:0] sum;
        found  = 1'b0;
        winner = ptr_reg;
        sum    = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_IN))
                sum = sum - (PTR_W+1)'(NUM_IN);
            if (eligible[sum[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[PTR_W-1:0];
            end
        end
    end

    assign ptr_next = (winner == PTR_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;

    // Slot is free when empty or when the held flit retires on this edge.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (found) begin
                    state_next = FULL;
                    load       = 1'b1;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (found) begin
                        state_next = FULL;
                        load       = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            grant_reg <= '0;
            data_reg  <= '0;
            ptr_reg   <= PTR_W'(PTR_RESET);
        end else begin
            state_reg <= state_next;
            grant_reg <= load ? win_onehot : '0;
            if (load) begin
                data_reg <= in_flit[winner];
                ptr_reg  <= ptr_next;
            end
        end
    end

    assign grant     = grant_reg;
    assign out_valid = (state_reg == FULL);
    assign out_data  = data_reg;

`ifdef ARB_GRANT_CNT_EN
    logic [15:0] cnt_reg [NUM_IN];

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset)
                    cnt_reg[gi] <= '0;
                else if (load && win_onehot[gi])
                    cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
            end
            assign grant_cnt[gi*16 +: 16] = cnt_reg[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed plus randomized bench for output_port_arbiter, checked against a transaction-level model.
module tb_output_port_arbiter;

    localparam int DW = 64;
    localparam int N  = 5;
    localparam int PR = 0;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
`ifdef ARB_GRANT_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    logic [DW-1:0]   din [N];

    // Reference model state
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic [N-1:0]    m_grant;
    int              m_ptr;
    logic [15:0]     m_cnt [N];

    int checks = 0;
    int fails  = 0;

    output_port_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .PTR_RESET(PR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = din[i];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the model one edge from the inputs that were stable before it.
    task automatic model_edge();
        bit slot_free;
        bit won;
        int w;
        logic [N-1:0] elig;
        logic [N-1:0] g_next;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_grant = '0;
            m_ptr   = PR;
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
            return;
        end
        slot_free = !m_valid || out_ready;
        elig      = req & ~m_grant;
        g_next    = '0;
        won       = 1'b0;
        w         = 0;
        if (slot_free) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!won && elig[idx]) begin
                    won = 1'b1;
                    w   = idx;
                end
            end
            if (won) begin
                m_data    = din[w];
                m_valid   = 1'b1;
                g_next[w] = 1'b1;
                m_ptr     = (w + 1) % N;
                m_cnt[w]  = m_cnt[w] + 16'd1;
                $display("t=%0t grant in=%0d flit=%h", $time, w, din[w]);
            end else begin
                m_valid = 1'b0;
            end
        end
        m_grant = g_next;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".grant"}, DW'(grant), DW'(m_grant));
        check({tag, ".out_valid"}, DW'(out_valid), DW'(m_valid));
        check({tag, ".out_data"}, out_data, m_data);
`ifdef ARB_GRANT_CNT_EN
        for (int i = 0; i < N; i++)
            check({tag, ".grant_cnt"}, DW'(grant_cnt[i*16 +: 16]), DW'(m_cnt[i]));
`endif
    endtask

    initial begin
        int rr_order [6];
        logic [DW-1:0] held;
        rr_order = '{0, 1, 2, 3, 4, 0};

        reset     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) din[i] = {32'hD000_0000 + 32'(i), 32'h0};
        m_valid = 1'b0; m_data = '0; m_grant = '0; m_ptr = PR;
        for (int i = 0; i < N; i++) m_cnt[i] = '0;

        // Reset state and idle with out_ready high
        step("reset");
        check("reset.grant_zero", DW'(grant), '0);
        check("reset.valid_zero", DW'(out_valid), '0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) step("idle");
        check("idle.valid", DW'(out_valid), '0);

        // Single request
        din[2] = 64'hA5;
        req    = 5'b00100;
        step("single");
        check("single.grant_lit", DW'(grant), DW'(5'b00100));
        check("single.data_lit", out_data, 64'hA5);
        req = '0;
        step("single_drain");

        // Round robin from PTR_RESET with all inputs requesting
        reset = 1'b1;
        step("rr_reset");
        reset = 1'b0;
        req   = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            step("rr");
            check("rr.order", DW'(grant), DW'(1 << rr_order[k]));
            check("rr.valid", DW'(out_valid), DW'(1'b1));
            din[rr_order[k]] = {$urandom, $urandom};
        end

        // Backpressure: held flit must not move, no grant
        held      = m_data;
        out_ready = 1'b0;
        req       = 5'b00010;
        for (int c = 0; c < 4; c++) begin
            step("bp_hold");
            check("bp.no_grant", DW'(grant), '0);
            check("bp.data_stable", out_data, held);
        end
        out_ready = 1'b1;
        step("bp_release");
        check("bp.grant_in1", DW'(grant), DW'(5'b00010));
        check("bp.data_in1", out_data, din[1]);
        req = '0;
        step("bp_drain");

        // Wrap: move ptr to 4, then 4 beats 0, then 0 wins next slot
        req = 5'b01000;
        step("wrap_setup");
        req = 5'b10001;
        step("wrap_p4");
        check("wrap.in4", DW'(grant), DW'(5'b10000));
        step("wrap_p0");
        check("wrap.in0", DW'(grant), DW'(5'b00001));
        req = '0;
        step("wrap_drain");

        // Reset while FULL with a pending request
        out_ready = 1'b0;
        req       = 5'b00100;
        step("mr_fill");
        req = 5'b00110;
        step("mr_busy");
        reset = 1'b1;
        step("mr_reset");
        check("mr.valid", DW'(out_valid), '0);
        check("mr.grant", DW'(grant), '0);
        reset     = 1'b0;
        out_ready = 1'b1;
        req       = 5'b11111;
        step("mr_after");
        check("mr.ptr_reset", DW'(grant), DW'(1 << PR));

        // Randomized traffic with contract-following requesters
        req = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_grant[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom % 2 == 0)) begin
                    req[i] = 1'b1;
                    din[i] = {$urandom, $urandom};
                end
            end
            out_ready = ($urandom % 4) != 0;
            reset     = ($urandom % 64) == 0;
            step("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
